// File: rtl/act_sram_wmask_gen.sv
// rtl/act_sram_wmask_gen.sv - activation SRAM write-mask/data assembly with optional same-address coalescing.
// Define WMASK_ZERO_UNUSED_EN to force unwritten lanes of out_data to zero.
module act_sram_wmask_gen #(
  parameter int CH_NUM       = 24,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 16,
  parameter int ADDR_W       = 10,
  parameter int DELAY        = 5
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic [$clog2(CH_NUM)-1:0]                 in_ch,
  input  logic [$clog2(ACT_PER_ADDR)-1:0]           in_pos,
  input  logic [ADDR_W-1:0]                         in_addr,
  input  logic [BW_PER_ACT-1:0]                     in_data,
  input  logic                                      coalesce_en,
  input  logic                                      flush,
  output logic                                      out_valid,
  output logic [ADDR_W-1:0]                         out_addr,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]            out_bytemask,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] out_data,
  output logic                                      pending,
  output logic                                      err_idx
);
  localparam int LANES  = CH_NUM * ACT_PER_ADDR;
  localparam int DW     = LANES * BW_PER_ACT;
  localparam int LANE_W = $clog2(LANES);
  localparam int OFF_W  = $clog2(DW);

  logic [ADDR_W-1:0] acc_addr;
  logic [LANES-1:0]  acc_mask;
  logic [DW-1:0]     acc_data;

  logic              idx_ok, take;
  logic [LANE_W-1:0] lane;
  logic [OFF_W-1:0]  off;
  logic [LANES-1:0]  lane_mask;
  logic [DW-1:0]     lane_data, merge_data;

  always_comb begin
    idx_ok    = (int'(in_ch) < CH_NUM) && (int'(in_pos) < ACT_PER_ADDR);
    take      = in_valid && idx_ok;
    lane      = idx_ok ? LANE_W'((CH_NUM - 1 - int'(in_ch)) * ACT_PER_ADDR +
                                 (ACT_PER_ADDR - 1 - int'(in_pos))) : '0;
    off       = OFF_W'(int'(lane) * BW_PER_ACT);
    lane_mask = ~(LANES'(1) << lane);
`ifdef WMASK_ZERO_UNUSED_EN
    lane_data = '0;
`else
    lane_data = acc_data;
`endif
    lane_data[off +: BW_PER_ACT]  = in_data;
    merge_data                    = acc_data;
    merge_data[off +: BW_PER_ACT] = in_data;
  end

  logic              co_mode, eff_flush, emit, npending;
  logic [ADDR_W-1:0] emit_addr, nacc_addr;
  logic [LANES-1:0]  emit_mask, nacc_mask;
  logic [DW-1:0]     emit_data, nacc_data;

  // Dropping coalesce_en while pending behaves as a flush with coalescing rules for that cycle.
  always_comb begin
    emit      = 1'b0;
    emit_addr = in_addr;
    emit_mask = lane_mask;
    emit_data = lane_data;
    npending  = pending;
    nacc_addr = acc_addr;
    nacc_mask = acc_mask;
    nacc_data = acc_data;
    co_mode   = coalesce_en || pending;
    eff_flush = flush || (!coalesce_en && pending);
    if (!co_mode) begin
      emit = take;
    end else if (pending && take && (in_addr != acc_addr)) begin
      emit      = 1'b1;
      emit_addr = acc_addr;
      emit_mask = acc_mask;
      emit_data = acc_data;
      nacc_addr = in_addr;
      nacc_mask = lane_mask;
      nacc_data = lane_data;
    end else begin
      if (take && pending) begin
        nacc_mask = acc_mask & lane_mask;
        nacc_data = merge_data;
      end else if (take) begin
        nacc_addr = in_addr;
        nacc_mask = lane_mask;
        nacc_data = lane_data;
      end
      npending = pending || take;
      if (npending && (eff_flush || (nacc_mask == '0))) begin
        emit      = 1'b1;
        emit_addr = nacc_addr;
        emit_mask = nacc_mask;
        emit_data = nacc_data;
        npending  = 1'b0;
      end
    end
  end

  logic [DELAY:0]    dl_valid;
  logic [ADDR_W-1:0] dl_addr [0:DELAY];
  logic [LANES-1:0]  dl_mask [0:DELAY];
  logic [DW-1:0]     dl_data [0:DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      err_idx  <= 1'b0;
      dl_valid <= '0;
    end else begin
      pending  <= npending;
      err_idx  <= in_valid && !idx_ok;
      dl_valid <= {dl_valid[DELAY-1:0], emit};
    end
  end

  always_ff @(posedge clk) begin
    acc_addr   <= nacc_addr;
    acc_mask   <= nacc_mask;
    acc_data   <= nacc_data;
    dl_addr[0] <= emit_addr;
    dl_mask[0] <= emit_mask;
    dl_data[0] <= emit_data;
    for (int i = 1; i <= DELAY; i++) begin
      dl_addr[i] <= dl_addr[i-1];
      dl_mask[i] <= dl_mask[i-1];
      dl_data[i] <= dl_data[i-1];
    end
  end

  // Address/mask payload is unreset, so idle values are forced from the valid bit.
  assign out_valid    = dl_valid[DELAY];
  assign out_addr     = out_valid ? dl_addr[DELAY] : '0;
  assign out_bytemask = out_valid ? dl_mask[DELAY] : '1;

`ifdef WMASK_ZERO_UNUSED_EN
  always_comb begin
    out_data = dl_data[DELAY];
    for (int i = 0; i < LANES; i++) begin
      if (out_bytemask[i]) out_data[i*BW_PER_ACT +: BW_PER_ACT] = '0;
    end
  end
`else
  assign out_data = dl_data[DELAY];
`endif
endmodule

// File: tb/tb_act_sram_wmask_gen.sv
// tb/tb_act_sram_wmask_gen.sv - randomized bench with a lane-set reference model for act_sram_wmask_gen.
module tb_act_sram_wmask_gen;
  localparam int CH_NUM = 24;
  localparam int APA    = 4;
  localparam int BW     = 16;
  localparam int AW     = 10;
  localparam int DELAY  = 5;
  localparam int LANES  = CH_NUM * APA;
  localparam int DW     = LANES * BW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [4:0]       in_ch = '0;
  logic [1:0]       in_pos = '0;
  logic [AW-1:0]    in_addr = '0;
  logic [BW-1:0]    in_data = '0;
  logic             coalesce_en = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [AW-1:0]    out_addr;
  logic [LANES-1:0] out_bytemask;
  logic [DW-1:0]    out_data;
  logic             pending;
  logic             err_idx;

  always #5 clk = ~clk;

  act_sram_wmask_gen #(
    .CH_NUM(CH_NUM), .ACT_PER_ADDR(APA), .BW_PER_ACT(BW), .ADDR_W(AW), .DELAY(DELAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_pos(in_pos),
    .in_addr(in_addr), .in_data(in_data), .coalesce_en(coalesce_en), .flush(flush),
    .out_valid(out_valid), .out_addr(out_addr), .out_bytemask(out_bytemask),
    .out_data(out_data), .pending(pending), .err_idx(err_idx)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: accumulator kept as a set of written lanes plus their values.
  typedef struct {
    int               due;
    logic [AW-1:0]    addr;
    logic [LANES-1:0] mask;
    logic [DW-1:0]    data;
  } wr_t;

  wr_t           q[$];
  int            cyc = 0;
  bit            m_pending = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  bit            m_set[LANES];
  logic [BW-1:0] m_val[LANES];

  task automatic push_acc();
    wr_t w;
    w.due  = cyc + DELAY;
    w.addr = m_addr;
    w.mask = '1;
    w.data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (m_set[l]) begin
        w.mask[l] = 1'b0;
        w.data[l*BW +: BW] = m_val[l];
      end
    end
    q.push_back(w);
  endtask

  task automatic load_acc(input int l);
    foreach (m_set[i]) m_set[i] = 1'b0;
    m_addr    = in_addr;
    m_set[l]  = 1'b1;
    m_val[l]  = in_data;
    m_pending = 1'b1;
  endtask

  task automatic model_step();
    bit  ok, take, full;
    int  l;
    wr_t w;
    cyc++;
    ok    = (int'(in_ch) < CH_NUM) && (int'(in_pos) < APA);
    take  = in_valid && ok;
    l     = (CH_NUM - 1 - int'(in_ch)) * APA + (APA - 1 - int'(in_pos));
    m_err = in_valid && !ok;
    if (!coalesce_en && !m_pending) begin
      if (take) begin
        w.due  = cyc + DELAY;
        w.addr = in_addr;
        w.mask = '1;
        w.mask[l] = 1'b0;
        w.data = '0;
        w.data[l*BW +: BW] = in_data;
        q.push_back(w);
      end
    end else if (take && m_pending && in_addr != m_addr) begin
      push_acc();
      load_acc(l);
    end else begin
      if (take && m_pending) begin
        m_set[l] = 1'b1;
        m_val[l] = in_data;
      end else if (take) begin
        load_acc(l);
      end
      full = 1'b1;
      foreach (m_set[i]) if (!m_set[i]) full = 1'b0;
      if (m_pending && (flush || !coalesce_en || full)) begin
        push_acc();
        m_pending = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pending = 1'b0;
      m_err     = 1'b0;
    end else begin
      model_step();
    end
  end

  bit chk_on = 1'b0;
  bit bad;

  always @(negedge clk) begin
    if (chk_on) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_write: addr %h due %0d never emitted", q[0].addr, q[0].due);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("out_valid", 128'(out_valid), 128'(1));
        chk("out_addr", 128'(out_addr), 128'(q[0].addr));
        chk("out_bytemask", 128'(out_bytemask), 128'(q[0].mask));
        bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          if (!q[0].mask[l] && out_data[l*BW +: BW] !== q[0].data[l*BW +: BW]) bad = 1'b1;
`ifdef WMASK_ZERO_UNUSED_EN
          if (q[0].mask[l] && out_data[l*BW +: BW] !== '0) bad = 1'b1;
`endif
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL out_data: lanes differ at addr %h (cycle %0d)", out_addr, cyc);
        end
        void'(q.pop_front());
      end else begin
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_out_addr", 128'(out_addr), 128'(0));
        chk("idle_out_bytemask", 128'(out_bytemask), {32'h0, {LANES{1'b1}}});
      end
      chk("err_idx", 128'(err_idx), 128'(m_err));
      chk("pending", 128'(pending), 128'(m_pending));
    end
  end

  task automatic send(input bit v, input int ch, input int pos, input int addr,
                      input logic [BW-1:0] d, input bit ce, input bit fl);
    in_valid    = v;
    in_ch       = 5'(ch);
    in_pos      = 2'(pos);
    in_addr     = AW'(addr);
    in_data     = d;
    coalesce_en = ce;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ce);
    repeat (n) send(1'b0, 0, 0, 0, '0, ce, 1'b0);
  endtask

  localparam logic [LANES-1:0] ONES = {LANES{1'b1}};

  bit ce;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_bytemask", 128'(out_bytemask), 128'(ONES));
    chk("rst_pending", 128'(pending), 128'(0));
    rst_n  = 1'b1;
    chk_on = 1'b1;
    idle(2, 1'b0);

    // Direct single write, lane 92
    send(1'b1, 0, 3, 5, 16'h1234, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_addr", 128'(out_addr), 128'(5));
    chk("t1_mask", 128'(out_bytemask), 128'(96'hEFFF_FFFF_FFFF_FFFF_FFFF_FFFF));
    chk("t1_data", 128'(out_data[1487:1472]), 128'(16'h1234));
    idle(2, 1'b0);

    // Direct back-to-back: lanes 3 and 88
    send(1'b1, 23, 0, 9, 16'hAAAA, 1'b0, 1'b0);
    send(1'b1, 1, 3, 9, 16'h5555, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("t2a_mask", 128'(out_bytemask), 128'(96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFF7));
    idle(1, 1'b0);
    chk("t2b_valid", 128'(out_valid), 128'(1));
    chk("t2b_mask", 128'(out_bytemask), 128'(96'hFEFF_FFFF_FFFF_FFFF_FFFF_FFFF));
    idle(3, 1'b0);

    // Coalesce all 96 lanes of address 7 into one write
    for (int c = 0; c < CH_NUM; c++) begin
      for (int p = 0; p < APA; p++) begin
        send(1'b1, c, p, 7, 16'(c * APA + p + 16'h100), 1'b1, 1'b0);
        if (c == 0 && p == 0) chk("t3_pending_set", 128'(pending), 128'(1));
      end
    end
    chk("t3_pending_clear", 128'(pending), 128'(0));
    idle(5, 1'b1);
    chk("t3_valid", 128'(out_valid), 128'(1));
    chk("t3_addr", 128'(out_addr), 128'(7));
    chk("t3_mask", 128'(out_bytemask), 128'(0));
    idle(2, 1'b1);

    // Address change then flush: lane 86 to addr 3, then addr 4
    send(1'b1, 2, 1, 3, 16'h0301, 1'b1, 1'b0);
    send(1'b1, 2, 1, 4, 16'h0401, 1'b1, 1'b0);
    send(1'b0, 0, 0, 0, '0, 1'b1, 1'b1);
    chk("t4_pending", 128'(pending), 128'(0));
    idle(4, 1'b1);
    chk("t4a_addr", 128'(out_addr), 128'(3));
    chk("t4a_mask", 128'(out_bytemask), 128'(96'hFFBF_FFFF_FFFF_FFFF_FFFF_FFFF));
    idle(1, 1'b1);
    chk("t4b_addr", 128'(out_addr), 128'(4));
    chk("t4b_mask", 128'(out_bytemask), 128'(96'hFFBF_FFFF_FFFF_FFFF_FFFF_FFFF));
    idle(2, 1'b1);

    // Out-of-range channel while pending
    send(1'b1, 0, 0, 2, 16'h0001, 1'b1, 1'b0);
    send(1'b1, 24, 0, 2, 16'h0002, 1'b1, 1'b0);
    chk("t5_err", 128'(err_idx), 128'(1));
    chk("t5_pending", 128'(pending), 128'(1));
    idle(1, 1'b1);
    chk("t5_err_clear", 128'(err_idx), 128'(0));
    send(1'b0, 0, 0, 0, '0, 1'b1, 1'b1);
    idle(7, 1'b1);

    // Reset with three writes in flight and the accumulator pending
    send(1'b1, 3, 1, 10, 16'hA001, 1'b0, 1'b0);
    send(1'b1, 4, 2, 11, 16'hA002, 1'b0, 1'b0);
    send(1'b1, 5, 3, 12, 16'hA003, 1'b0, 1'b0);
    send(1'b1, 6, 0, 13, 16'hA004, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_pending", 128'(pending), 128'(0));
    chk("t6_err", 128'(err_idx), 128'(0));
    chk("t6_addr", 128'(out_addr), 128'(0));
    chk("t6_mask", 128'(out_bytemask), 128'(ONES));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(10, 1'b0);

    // Randomized traffic over a small address set to provoke merges and switches
    ce = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ce = !ce;
      send($urandom_range(0, 3) != 0,
           ($urandom_range(0, 15) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom),
           ce, $urandom_range(0, 15) == 0);
    end
    idle(DELAY + 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
